// File: rtl/arf066b064e1r1w0cbbehsaa4acw_hs_pkg.sv
// Shared types and default sizing for the req/ack transmit crossing.
package arf066b064e1r1w0cbbehsaa4acw_hs_pkg;

  localparam int unsigned HS_DATA_W      = 66;
  localparam int unsigned HS_CNT_W       = 16;
  localparam int unsigned HS_TIMEOUT_CYC = 1024;
  localparam int unsigned SYNC_STAGES    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_tx_state_t;

endpackage

// File: rtl/arf066b064e1r1w0cbbehsaa4acw_ctech_doublesync.sv
// Multi-flop synchronizer cell for a single asynchronous level signal.
module arf066b064e1r1w0cbbehsaa4acw_ctech_doublesync
  import arf066b064e1r1w0cbbehsaa4acw_hs_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic d,
  input  logic clk,
  output logic o
);

  logic [STAGES-1:0] sync_q;

  // No reset: the chain must keep tracking the far side through a local reset.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign o = sync_q[STAGES-1];

endmodule

// File: rtl/arf066b064e1r1w0cbbehsaa4acw_hs_tx.sv
// Transmit end of a 4-phase req/ack crossing into an asynchronous consumer domain.
// Optional watchdog enabled by ARF066B064E1R1W0CBBEHSAA4ACW_HS_TX_TIMEOUT_EN.
module arf066b064e1r1w0cbbehsaa4acw_hs_tx
  import arf066b064e1r1w0cbbehsaa4acw_hs_pkg::*;
#(
  parameter int unsigned DATA_W      = HS_DATA_W,
  parameter int unsigned CNT_W       = HS_CNT_W,
  parameter int unsigned TIMEOUT_CYC = HS_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_ack,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              timeout_err
);

  hs_tx_state_t      state_q, state_d;
  logic              tx_req_q, tx_req_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic              ack_s;
  logic              accept_c;
  logic              expire_c;

  arf066b064e1r1w0cbbehsaa4acw_ctech_doublesync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .d  (rx_ack),
    .clk(clk),
    .o  (ack_s)
  );

  // A stale ack from the far side blocks any new request.
  assign in_ready = (state_q == IDLE) && !ack_s;
  assign accept_c = in_valid && in_ready;

`ifdef ARF066B064E1R1W0CBBEHSAA4ACW_HS_TX_TIMEOUT_EN
  localparam int unsigned      WAIT_W    = (TIMEOUT_CYC >= 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_err_q, timeout_err_d;

  assign expire_c = (state_q != IDLE) && (wait_q == WAIT_LAST);

  // Wait counter restarts on every state change and runs only while handshaking.
  always_comb begin
    wait_d        = wait_q;
    timeout_err_d = timeout_err_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (state_q != IDLE) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    if (expire_c) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_q        <= wait_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign expire_c           = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  // Handshake sequencing: capture on accept, drop req on ack, count on ack release.
  always_comb begin
    state_d    = state_q;
    tx_req_d   = tx_req_q;
    tx_data_d  = tx_data_q;
    xfer_cnt_d = xfer_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d   = REQ;
          tx_req_d  = 1'b1;
          tx_data_d = in_data;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d  = REL;
          tx_req_d = 1'b0;
        end
      end
      REL: begin
        if (!ack_s) begin
          state_d    = IDLE;
          xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        tx_req_d = 1'b0;
      end
    endcase
    // Watchdog abort overrides the normal progression and is never counted.
    if (expire_c) begin
      state_d    = IDLE;
      tx_req_d   = 1'b0;
      xfer_cnt_d = xfer_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_req_q   <= 1'b0;
      tx_data_q  <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign tx_req   = tx_req_q;
  assign tx_data  = tx_data_q;
  assign xfer_cnt = xfer_cnt_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_arf066b064e1r1w0cbbehsaa4acw_hs_tx.sv
// Scoreboard bench for the req/ack transmit crossing (small counter, short watchdog).
module tb_arf066b064e1r1w0cbbehsaa4acw_hs_tx;

  localparam int unsigned DW      = 66;
  localparam int unsigned CW      = 4;
  localparam int unsigned ACK_DLY = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic          rx_ack;
  logic          busy;
  logic [CW-1:0] xfer_cnt;
  logic          timeout_err;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] words[0:16];
  bit            far_auto;
  logic          mon_prev_req;
  int            mon_hi_len;
  logic [DW-1:0] mon_cur;

  arf066b064e1r1w0cbbehsaa4acw_hs_tx #(
    .DATA_W     (DW),
    .CNT_W      (CW),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .rx_ack     (rx_ack),
    .busy       (busy),
    .xfer_cnt   (xfer_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer words[0..n-1] with in_valid held continuously until all are accepted.
  task automatic send(input int n);
    int idx    = 0;
    int budget = 4000;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = words[0];
    while (idx < n && budget > 0) begin
      if (in_ready) begin
        exp_q.push_back(words[idx]);
        idx++;
      end
      @(negedge clk);
      budget--;
      if (idx < n) in_data = words[idx];
    end
    in_valid = 1'b0;
    chk("send_accepted_all", 128'(idx), 128'(n));
  endtask

  task automatic wait_ready(input string name);
    int budget = 500;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(name, 128'(in_ready), 128'(1));
  endtask

  // Far-side consumer: answers each req edge after ACK_DLY cycles.
  initial begin
    rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (far_auto && !rst) begin
        if (tx_req && !rx_ack) begin
          repeat (ACK_DLY) @(negedge clk);
          rx_ack = 1'b1;
        end else if (!tx_req && rx_ack) begin
          repeat (ACK_DLY) @(negedge clk);
          rx_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expected payload on each req rise, checks hold and req length.
  initial begin
    mon_prev_req = 1'b0;
    mon_hi_len   = 0;
    mon_cur      = '0;
    forever begin
      @(negedge clk);
      if (in_ready) chk("ready_only_when_idle", 128'(busy), 128'(0));
      if (tx_req && !mon_prev_req) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL req_without_accept: tx_data %0h with empty queue", tx_data);
        end else begin
          mon_cur = exp_q.pop_front();
          if (tx_data !== mon_cur) begin
            n_fail++;
            $display("FAIL tx_data_at_req: got %0h expected %0h", tx_data, mon_cur);
          end
        end
        mon_hi_len = 1;
      end else if (tx_req && mon_prev_req) begin
        chk("tx_data_stable", 128'(tx_data), 128'(mon_cur));
        mon_hi_len++;
      end else if (!tx_req && mon_prev_req && far_auto) begin
        chk("req_high_cycles", 128'(mon_hi_len), 128'(ACK_DLY + 3));
      end
      mon_prev_req = tx_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    far_auto = 1'b1;
    for (int i = 0; i < 17; i++) begin
      words[i] = {2'(i), 32'hC0DE_0000 + 32'(i * 17), 32'h5A5A_0000 + 32'(i)};
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_tx_req", 128'(tx_req), 128'(0));
    chk("rst_tx_data", 128'(tx_data), 128'(0));
    chk("rst_xfer_cnt", 128'(xfer_cnt), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_timeout_err", 128'(timeout_err), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // single transfer
    words[0] = 66'h2_DEAD_BEEF_0123_4567;
    send(1);
    chk("single_cnt_during", 128'(xfer_cnt), 128'(0));
    chk("single_busy", 128'(busy), 128'(1));
    wait_ready("single_done");
    chk("single_cnt_after", 128'(xfer_cnt), 128'(1));
    chk("single_data_held", 128'(tx_data), 128'(66'h2_DEAD_BEEF_0123_4567));

    // back-to-back
    for (int i = 0; i < 17; i++) words[i] = {2'(i), 32'hC0DE_0000 + 32'(i * 17), 32'h5A5A_0000 + 32'(i)};
    do_reset();
    send(4);
    wait_ready("b2b_done");
    chk("b2b_cnt", 128'(xfer_cnt), 128'(4));
    chk("b2b_last_data", 128'(tx_data), 128'(words[3]));

    // stale ack across reset
    do_reset();
    far_auto = 1'b0;
    send(1);
    rx_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("stale_req_dropped", 128'(tx_req), 128'(0));
    chk("stale_busy", 128'(busy), 128'(0));
    chk("stale_ready_in_rst", 128'(in_ready), 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stale_ready_blocked", 128'(in_ready), 128'(0));
    end
    rx_ack = 1'b0;
    @(negedge clk);
    chk("stale_ready_1cyc", 128'(in_ready), 128'(0));
    @(negedge clk);
    chk("stale_ready_2cyc", 128'(in_ready), 128'(1));
    chk("stale_cnt", 128'(xfer_cnt), 128'(0));
    far_auto = 1'b1;

    // counter wrap
    do_reset();
    send(17);
    wait_ready("wrap_done");
    chk("wrap_cnt", 128'(xfer_cnt), 128'(1));

    // watchdog behaviour with an ack that never rises
    do_reset();
    far_auto = 1'b0;
    words[0] = 66'h1_0BAD_F00D_CAFE_0001;
    send(1);
`ifdef ARF066B064E1R1W0CBBEHSAA4ACW_HS_TX_TIMEOUT_EN
    repeat (7) @(negedge clk);
    chk("to_err_before", 128'(timeout_err), 128'(0));
    chk("to_req_before", 128'(tx_req), 128'(1));
    @(negedge clk);
    chk("to_err_set", 128'(timeout_err), 128'(1));
    chk("to_req_dropped", 128'(tx_req), 128'(0));
    chk("to_idle", 128'(busy), 128'(0));
    chk("to_cnt", 128'(xfer_cnt), 128'(0));
    chk("to_ready", 128'(in_ready), 128'(1));
    repeat (5) @(negedge clk);
    chk("to_sticky", 128'(timeout_err), 128'(1));
    do_reset();
    chk("to_cleared", 128'(timeout_err), 128'(0));
`else
    repeat (40) @(negedge clk);
    chk("noto_req_held", 128'(tx_req), 128'(1));
    chk("noto_busy", 128'(busy), 128'(1));
    chk("noto_err", 128'(timeout_err), 128'(0));
    rx_ack = 1'b1;
    begin
      int budget = 50;
      while (tx_req && budget > 0) begin
        @(negedge clk);
        budget--;
      end
    end
    chk("noto_req_release", 128'(tx_req), 128'(0));
    rx_ack = 1'b0;
    wait_ready("noto_done");
    chk("noto_cnt", 128'(xfer_cnt), 128'(1));
`endif
    far_auto = 1'b1;
    chk("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
